// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory fetch/debug arbiter.
package imem_arb_pkg;

    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of arbitrations the debug port lost while requesting.
module imem_arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    // at_limit is registered from the next count so it is valid in the cycle after saturation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            at_limit <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_limit <= (cnt_d == LIMIT_V);
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares the synchronous instruction-memory read port between fetch (F) and debug (D).
module imem_fetch_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned INS_ADDRESS  = 9,
    parameter int unsigned INS_W        = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   f_req_valid,
    input  logic [INS_ADDRESS-1:0] f_req_addr,
    output logic                   f_req_ready,
    input  logic                   f_flush,
    output logic                   f_rsp_valid,
    output logic [INS_W-1:0]       f_rsp_data,
    output logic                   f_rsp_err,
    input  logic                   f_rsp_ready,
    input  logic                   d_req_valid,
    input  logic [INS_ADDRESS-1:0] d_req_addr,
    output logic                   d_req_ready,
    output logic                   d_rsp_valid,
    output logic [INS_W-1:0]       d_rsp_data,
    output logic                   d_rsp_err,
    input  logic                   d_rsp_ready,
    output logic [INS_ADDRESS-1:0] mem_addr,
    input  logic [INS_W-1:0]       mem_rdata
);

    arb_state_t             state_q, state_d;
    arb_owner_t             owner_q;
    logic [INS_ADDRESS-1:0] mem_addr_q;
    logic [INS_W-1:0]       rsp_data_q;
    logic                   rsp_err_q;
    logic                   f_rsp_valid_q;
    logic                   d_rsp_valid_q;

    logic own_hs;
    logic flush_own;
    logic grant_ok;
    logic d_wins;
    logic f_grant;
    logic d_grant;
    logic starve_at_limit;

    imem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (d_req_valid && f_grant),
        .clr      (d_grant),
        .at_limit (starve_at_limit)
    );

    // Grant decision, next state and memory address mux
    always_comb begin
        state_d   = state_q;
        own_hs    = (owner_q == OWN_F) ? (f_rsp_valid_q && f_rsp_ready)
                                       : (d_rsp_valid_q && d_rsp_ready);
        flush_own = f_flush && (owner_q == OWN_F);
        grant_ok  = (state_q == IDLE) || ((state_q == RSP) && own_hs);
        d_wins    = d_req_valid && (!f_req_valid || starve_at_limit);
        f_grant   = grant_ok && f_req_valid && !d_wins;
        d_grant   = grant_ok && d_wins;
        mem_addr  = mem_addr_q;
        if (d_grant) begin
            mem_addr = d_req_addr;
        end else if (f_grant) begin
            mem_addr = f_req_addr;
        end

        case (state_q)
            IDLE: begin
                if (f_grant || d_grant) state_d = RD;
            end
            RD: begin
                state_d = flush_own ? IDLE : RSP;
            end
            RSP: begin
                if (f_grant || d_grant) begin
                    state_d = RD;
                end else if (own_hs || flush_own) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_F;
            mem_addr_q    <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            f_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr;
            if (f_grant || d_grant) begin
                owner_q   <= d_grant ? OWN_D : OWN_F;
                rsp_err_q <= |mem_addr[1:0];
            end
            if ((state_q == RD) && !flush_own) begin
                rsp_data_q <= mem_rdata;
            end
            // A flushed fetch read never raises valid; a flushed held response drops
            if ((state_q == RD) && !flush_own && (owner_q == OWN_F)) begin
                f_rsp_valid_q <= 1'b1;
            end else if (f_rsp_valid_q && (f_rsp_ready || f_flush)) begin
                f_rsp_valid_q <= 1'b0;
            end
            if ((state_q == RD) && (owner_q == OWN_D)) begin
                d_rsp_valid_q <= 1'b1;
            end else if (d_rsp_valid_q && d_rsp_ready) begin
                d_rsp_valid_q <= 1'b0;
            end
        end
    end

    assign f_req_ready = f_grant;
    assign d_req_ready = d_grant;
    assign f_rsp_valid = f_rsp_valid_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign f_rsp_data  = rsp_data_q;
    assign d_rsp_data  = rsp_data_q;
    assign f_rsp_err   = rsp_err_q;
    assign d_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed vector bench for imem_fetch_arbiter with a synchronous memory model.
module tb_imem_fetch_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req_valid = 1'b0;
    logic [AW-1:0] f_req_addr = '0;
    logic          f_req_ready;
    logic          f_flush = 1'b0;
    logic          f_rsp_valid;
    logic [DW-1:0] f_rsp_data;
    logic          f_rsp_err;
    logic          f_rsp_ready = 1'b0;
    logic          d_req_valid = 1'b0;
    logic [AW-1:0] d_req_addr = '0;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          d_rsp_err;
    logic          d_rsp_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    imem_fetch_arbiter #(
        .INS_ADDRESS  (AW),
        .INS_W        (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_flush     (f_flush),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_err   (f_rsp_err),
        .f_rsp_ready (f_rsp_ready),
        .d_req_valid (d_req_valid),
        .d_req_addr  (d_req_addr),
        .d_req_ready (d_req_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err),
        .d_rsp_ready (d_rsp_ready),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    always @(posedge clk) mem_rdata <= memf(mem_addr);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          fv;
        logic [AW-1:0] fa;
        logic          fl;
        logic          frr;
        logic          dv;
        logic [AW-1:0] da;
        logic          drr;
        logic          e_frdy;
        logic          e_drdy;
        logic [AW-1:0] e_ma;
        logic          e_fvld;
        logic          e_dvld;
        logic          e_err;
        logic [DW-1:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic fv, input logic [AW-1:0] fa, input logic fl,
                                input logic frr, input logic dv, input logic [AW-1:0] da,
                                input logic drr, input logic e_frdy, input logic e_drdy,
                                input logic [AW-1:0] e_ma, input logic e_fvld,
                                input logic e_dvld, input logic e_err, input logic [DW-1:0] e_data);
        vec_t v;
        v.fv = fv; v.fa = fa; v.fl = fl; v.frr = frr;
        v.dv = dv; v.da = da; v.drr = drr;
        v.e_frdy = e_frdy; v.e_drdy = e_drdy; v.e_ma = e_ma;
        v.e_fvld = e_fvld; v.e_dvld = e_dvld; v.e_err = e_err; v.e_data = e_data;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [DW-1:0] held;
    int k;

    initial begin
        // F basic back-to-back, misaligned, flush in RD, D with ignored flush, flush in RSP
        vecs.push_back(mk(1,9'h010,0,1, 0,9'h000,0, 1,0,9'h010,0,0,0,0));
        vecs.push_back(mk(1,9'h010,0,1, 0,9'h000,0, 0,0,9'h010,0,0,0,0));
        vecs.push_back(mk(1,9'h010,0,1, 0,9'h000,0, 1,0,9'h010,1,0,0,32'hC0DE0010));
        vecs.push_back(mk(1,9'h010,0,1, 0,9'h000,0, 0,0,9'h010,0,0,0,0));
        vecs.push_back(mk(0,9'h010,0,1, 0,9'h000,0, 0,0,9'h010,1,0,0,32'hC0DE0010));
        vecs.push_back(mk(0,9'h010,0,1, 0,9'h000,0, 0,0,9'h010,0,0,0,0));
        vecs.push_back(mk(1,9'h013,0,1, 0,9'h000,0, 1,0,9'h013,0,0,0,0));
        vecs.push_back(mk(0,9'h013,0,1, 0,9'h000,0, 0,0,9'h013,0,0,0,0));
        vecs.push_back(mk(0,9'h013,0,1, 0,9'h000,0, 0,0,9'h013,1,0,1,32'hC0DE0013));
        vecs.push_back(mk(1,9'h044,0,1, 0,9'h000,0, 1,0,9'h044,0,0,0,0));
        vecs.push_back(mk(0,9'h044,1,1, 0,9'h000,0, 0,0,9'h044,0,0,0,0));
        vecs.push_back(mk(0,9'h044,0,1, 0,9'h000,0, 0,0,9'h044,0,0,0,0));
        vecs.push_back(mk(1,9'h048,0,1, 0,9'h000,0, 1,0,9'h048,0,0,0,0));
        vecs.push_back(mk(0,9'h048,0,1, 0,9'h000,0, 0,0,9'h048,0,0,0,0));
        vecs.push_back(mk(0,9'h048,0,1, 0,9'h000,0, 0,0,9'h048,1,0,0,32'hC0DE0048));
        vecs.push_back(mk(0,9'h000,0,1, 1,9'h104,1, 0,1,9'h104,0,0,0,0));
        vecs.push_back(mk(0,9'h000,1,1, 0,9'h104,1, 0,0,9'h104,0,0,0,0));
        vecs.push_back(mk(0,9'h000,0,1, 0,9'h104,1, 0,0,9'h104,0,1,0,32'hC0DE0104));
        vecs.push_back(mk(1,9'h050,0,1, 0,9'h000,1, 1,0,9'h050,0,0,0,0));
        vecs.push_back(mk(0,9'h050,0,1, 0,9'h000,1, 0,0,9'h050,0,0,0,0));
        vecs.push_back(mk(0,9'h050,0,0, 0,9'h000,1, 0,0,9'h050,1,0,0,32'hC0DE0050));
        vecs.push_back(mk(0,9'h050,1,0, 0,9'h000,1, 0,0,9'h050,1,0,0,32'hC0DE0050));
        vecs.push_back(mk(0,9'h050,0,0, 0,9'h000,1, 0,0,9'h050,0,0,0,0));
        vecs.push_back(mk(1,9'h058,1,1, 0,9'h000,1, 1,0,9'h058,0,0,0,0));
        vecs.push_back(mk(0,9'h058,0,1, 0,9'h000,1, 0,0,9'h058,0,0,0,0));
        vecs.push_back(mk(0,9'h058,0,1, 0,9'h000,1, 0,0,9'h058,1,0,0,32'hC0DE0058));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_f_req_ready", DW'(f_req_ready), 0);
        chk("rst_d_req_ready", DW'(d_req_ready), 0);
        chk("rst_f_rsp_valid", DW'(f_rsp_valid), 0);
        chk("rst_d_rsp_valid", DW'(d_rsp_valid), 0);
        chk("rst_f_rsp_data", f_rsp_data, 0);
        chk("rst_f_rsp_err", DW'(f_rsp_err), 0);
        chk("rst_mem_addr", DW'(mem_addr), 0);
        reset_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            f_req_valid = vecs[i].fv;  f_req_addr = vecs[i].fa;
            f_flush     = vecs[i].fl;  f_rsp_ready = vecs[i].frr;
            d_req_valid = vecs[i].dv;  d_req_addr = vecs[i].da;
            d_rsp_ready = vecs[i].drr;
            @(negedge clk);
            chk($sformatf("v%0d_f_req_ready", i), DW'(f_req_ready), DW'(vecs[i].e_frdy));
            chk($sformatf("v%0d_d_req_ready", i), DW'(d_req_ready), DW'(vecs[i].e_drdy));
            chk($sformatf("v%0d_mem_addr", i), DW'(mem_addr), DW'(vecs[i].e_ma));
            chk($sformatf("v%0d_f_rsp_valid", i), DW'(f_rsp_valid), DW'(vecs[i].e_fvld));
            chk($sformatf("v%0d_d_rsp_valid", i), DW'(d_rsp_valid), DW'(vecs[i].e_dvld));
            if (vecs[i].e_fvld) begin
                chk($sformatf("v%0d_f_rsp_data", i), f_rsp_data, vecs[i].e_data);
                chk($sformatf("v%0d_f_rsp_err", i), DW'(f_rsp_err), DW'(vecs[i].e_err));
            end
            if (vecs[i].e_dvld) begin
                chk($sformatf("v%0d_d_rsp_data", i), d_rsp_data, vecs[i].e_data);
                chk($sformatf("v%0d_d_rsp_err", i), DW'(d_rsp_err), DW'(vecs[i].e_err));
            end
            next_cycle();
        end

        // Both ports requesting continuously: four F grants then one D grant, repeating
        f_flush = 0; f_rsp_ready = 1; d_rsp_ready = 1;
        f_req_valid = 1; f_req_addr = 9'h020;
        d_req_valid = 1; d_req_addr = 9'h104;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("starve_one_ready", DW'(f_req_ready & d_req_ready), 0);
            chk("starve_grant_slot", DW'(f_req_ready | d_req_ready), DW'((i % 2) == 0));
            if (f_req_ready || d_req_ready) begin
                chk($sformatf("starve_winner_d_k%0d", k), DW'(d_req_ready), DW'((k % 5) == 4));
                k++;
            end
            if (f_rsp_valid) chk("starve_f_data", f_rsp_data, memf(9'h020));
            if (d_rsp_valid) chk("starve_d_data", d_rsp_data, memf(9'h104));
            next_cycle();
        end
        chk("starve_grant_count", DW'(k), 20);
        f_req_valid = 0; d_req_valid = 0;
        repeat (3) next_cycle();

        // Debug response held under backpressure while fetch waits
        d_rsp_ready = 0;
        d_req_valid = 1; d_req_addr = 9'h108;
        @(negedge clk);
        chk("bp_d_grant", DW'(d_req_ready), 1);
        next_cycle();
        d_req_valid = 0; f_req_valid = 1; f_req_addr = 9'h030;
        @(negedge clk);
        chk("bp_rd_no_grant", DW'(f_req_ready), 0);
        next_cycle();
        held = memf(9'h108);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_d_valid", DW'(d_rsp_valid), 1);
            chk("bp_d_data", d_rsp_data, held);
            chk("bp_f_stall", DW'(f_req_ready), 0);
            next_cycle();
        end
        d_rsp_ready = 1;
        @(negedge clk);
        chk("bp_release_f_grant", DW'(f_req_ready), 1);
        chk("bp_release_addr", DW'(mem_addr), DW'(9'h030));
        next_cycle();
        f_req_valid = 0;
        @(negedge clk);
        chk("bp_d_valid_drop", DW'(d_rsp_valid), 0);
        next_cycle();
        @(negedge clk);
        chk("bp_f_valid", DW'(f_rsp_valid), 1);
        chk("bp_f_data", f_rsp_data, memf(9'h030));
        next_cycle();

        // Asynchronous reset while a read is outstanding
        f_req_valid = 1; f_req_addr = 9'h060;
        @(negedge clk);
        chk("rst_mid_grant", DW'(f_req_ready), 1);
        next_cycle();
        f_req_valid = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_f_valid", DW'(f_rsp_valid), 0);
        chk("rst_mid_d_valid", DW'(d_rsp_valid), 0);
        chk("rst_mid_mem_addr", DW'(mem_addr), 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_after_no_rsp", DW'(f_rsp_valid), 0);
            chk("rst_after_data", f_rsp_data, 0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
